// File: rtl/sram_array_pkg.sv
// Shared types and constants for the multi-bank input memory.
// BROADCAST_WR_EN: when defined, the all-ones bank index writes every bank at once.
package sram_array_pkg;

  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } seq_state_e;

  // Bank-select width: ceil(log2(num_banks)), at least 1; with broadcast the
  // all-ones code must lie outside the real bank range.
  function automatic int unsigned calc_bank_w(input int unsigned num_banks);
    int unsigned w;
    w = 1;
    while ((32'(1) << w) < num_banks) w++;
`ifdef BROADCAST_WR_EN
    if (((32'(1) << w) - 1) < num_banks) w++;
`endif
    return w;
  endfunction

endpackage

// File: rtl/sram_bank_array_if.sv
// Load port, stream control and valid/ready output of the bank array.
interface sram_bank_array_if #(
  parameter int unsigned NUM_BANKS = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 256
);
  import sram_array_pkg::*;

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BANK_W = calc_bank_w(NUM_BANKS);

  logic                        wr_en;
  logic [BANK_W-1:0]           wr_bank;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        wr_err;
  logic                        start;
  logic [ADDR_W-1:0]           rd_base;
  logic [ADDR_W:0]             rd_len;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_BANKS*DATA_W-1:0] out_data;
  logic                        out_last;
  logic                        done;

  modport master (
    output wr_en, wr_bank, wr_addr, wr_data, start, rd_base, rd_len, out_ready,
    input  wr_err, busy, out_valid, out_data, out_last, done
  );

  modport slave (
    input  wr_en, wr_bank, wr_addr, wr_data, start, rd_base, rd_len, out_ready,
    output wr_err, busy, out_valid, out_data, out_last, done
  );

endinterface

// File: rtl/sram_bank.sv
// Single-port synchronous RAM, one-cycle read latency. Contents are never reset.
module sram_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on strobe; read the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (write) mem[address] <= wdata;
    rdata <= mem[address];
  end

endmodule

// File: rtl/sram_bank_array.sv
// Multi-bank input memory: host load port plus a start-triggered read sequencer
// streaming a wrapping address range from all banks over valid/ready.
// BROADCAST_WR_EN: when defined, wr_bank all-ones writes every bank.
module sram_bank_array #(
  parameter int unsigned NUM_BANKS = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 256
) (
  input logic              clk,
  input logic              reset,
  sram_bank_array_if.slave bus
);
  import sram_array_pkg::*;

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned OUT_W  = NUM_BANKS * DATA_W;

  seq_state_e        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic              inflight_q;
  logic              done_q;
  logic              wr_err_q;

  logic [OUT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  logic [OUT_W-1:0]  bank_rdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] bank_addr;
  logic              bcast;
  logic              bank_ok;
  logic              wr_ok;
  logic              out_valid;
  logic              pop;
  logic              pop_fifo;
  logic              push;
  logic              issue;
  logic              last_issue;
  logic              last_beat;
  logic [2:0]        occ;

`ifdef BROADCAST_WR_EN
  assign bcast = &bus.wr_bank;
`else
  assign bcast = 1'b0;
`endif

  assign bank_ok = bcast || (32'(bus.wr_bank) < NUM_BANKS);
  assign wr_ok   = bus.wr_en && (state_q == StIdle) && bank_ok;

  // Address arithmetic wraps modulo DEPTH by truncation.
  assign rd_addr   = base_q + issue_cnt_q[ADDR_W-1:0];
  assign bank_addr = (state_q == StRun) ? rd_addr : bus.wr_addr;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic bank_we;
    assign bank_we = wr_ok && (bcast || (32'(bus.wr_bank) == k));
    sram_bank #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk    (clk),
      .write  (bank_we),
      .address(bank_addr),
      .wdata  (bus.wr_data),
      .rdata  (bank_rdata[k*DATA_W +: DATA_W])
    );
  end

  // A returning read bypasses the empty FIFO so the first beat appears one
  // cycle after issue; otherwise it is queued behind older entries.
  assign out_valid = (count_q != 2'd0) || inflight_q;
  assign pop       = out_valid && bus.out_ready;
  assign pop_fifo  = (count_q != 2'd0) && bus.out_ready;
  assign push      = inflight_q && !((count_q == 2'd0) && bus.out_ready);

  // Occupancy after this cycle's pop; a new read may only claim a free slot.
  assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue = (state_q == StRun) && (occ < 3'(FIFO_DEPTH));

  assign last_issue = issue_cnt_q == (len_q - LEN_W'(1));
  assign last_beat  = beat_cnt_q == (len_q - LEN_W'(1));

  assign bus.out_valid = out_valid;
  assign bus.out_data  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] :
                         (inflight_q ? bank_rdata : '0);
  assign bus.out_last  = out_valid && last_beat;
  assign bus.busy      = state_q != StIdle;
  assign bus.done      = done_q;
  assign bus.wr_err    = wr_err_q;

  // Sequencer FSM with issue/beat counters and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      wr_err_q   <= bus.wr_en && !wr_ok;
      inflight_q <= issue;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.rd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= StRun;
              base_q      <= bus.rd_base;
              len_q       <= bus.rd_len;
              issue_cnt_q <= '0;
              beat_cnt_q  <= '0;
            end
          end
        end
        StRun: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + LEN_W'(1);
            if (last_issue) state_q <= StDrain;
          end
          if (pop) beat_cnt_q <= beat_cnt_q + LEN_W'(1);
        end
        StDrain: begin
          if (pop) begin
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (last_beat) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-entry output FIFO holding words that could not be handed off directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bank_rdata;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop_fifo) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop_fifo);
    end
  end

endmodule

// File: tb/tb_sram_bank_array.sv
// Directed self-checking bench for sram_bank_array (10 banks x 16 bit x 256).
module tb_sram_bank_array;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  sram_bank_array_if #(.NUM_BANKS(10), .DATA_W(16), .DEPTH(256)) bus ();

  sram_bank_array #(
    .NUM_BANKS(10),
    .DATA_W   (16),
    .DEPTH    (256)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Loaded pattern: bank k at address a holds {k, a[7:0]}.
  function automatic logic [159:0] exp_beat(input logic [7:0] addr);
    logic [159:0] v;
    for (int k = 0; k < 10; k++) v[k*16 +: 16] = {8'(k), addr};
    return v;
  endfunction

  task automatic write_word(input int bank, input int addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_bank = 4'(bank);
    bus.wr_addr = 8'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Full-throughput stream with cycle-exact timing checks.
  task automatic stream_full(input string tag, input logic [7:0] base, input int len);
    bus.start     = 1'b1;
    bus.rd_base   = base;
    bus.rd_len    = 9'(len);
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq({tag, "_t1_valid"}, bus.out_valid, 0);
    check_eq({tag, "_t1_busy"}, bus.busy, 1);
    for (int i = 0; i < len; i++) begin
      tick();
      check_eq({tag, "_valid"}, bus.out_valid, 1);
      check_eq({tag, "_data"}, bus.out_data, exp_beat(8'(int'(base) + i)));
      check_eq({tag, "_last"}, bus.out_last, (i == len - 1));
      check_eq({tag, "_nodone"}, bus.done, 0);
    end
    tick();
    check_eq({tag, "_done"}, bus.done, 1);
    check_eq({tag, "_busy_end"}, bus.busy, 0);
    check_eq({tag, "_valid_end"}, bus.out_valid, 0);
    tick();
    check_eq({tag, "_done_pulse"}, bus.done, 0);
  endtask

  // Drain a running stream with ready high, counting beats until done.
  task automatic drain(input string tag, input logic [7:0] base, input int exp_len);
    int n;
    int cyc;
    bit seen_done;
    n = 0;
    cyc = 0;
    seen_done = 1'b0;
    bus.out_ready = 1'b1;
    while (!seen_done && cyc < 40) begin
      if (bus.done) begin
        seen_done = 1'b1;
      end else if (bus.out_valid) begin
        check_eq({tag, "_data"}, bus.out_data, exp_beat(8'(int'(base) + n)));
        check_eq({tag, "_last"}, bus.out_last, (n == exp_len - 1));
        n++;
      end
      if (!seen_done) tick();
      cyc++;
    end
    check_eq({tag, "_done_seen"}, seen_done, 1);
    check_eq({tag, "_beats"}, n, exp_len);
  endtask

  initial begin
    logic [15:0]  pat;
    logic [159:0] prev_data;
    logic [159:0] exp_v;
    bit           have_prev;
    int           n;
    int           c;

    vec_cnt = 0;
    err_cnt = 0;
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_bank   = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.start     = 1'b0;
    bus.rd_base   = '0;
    bus.rd_len    = '0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_wr_err", bus.wr_err, 0);
    check_eq("rst_data", bus.out_data, 0);
    check_eq("rst_last", bus.out_last, 0);
    reset = 1'b0;
    tick();

    // Load addresses 0..8 and 254..255 of every bank.
    for (int k = 0; k < 10; k++) begin
      for (int a = 0; a < 9; a++) write_word(k, a, 16'((k << 8) | a));
      write_word(k, 254, 16'((k << 8) | 254));
      write_word(k, 255, 16'((k << 8) | 255));
    end
    check_eq("load_no_err", bus.wr_err, 0);
    tick();

    stream_full("base0", 8'd0, 8);
    stream_full("wrap", 8'd254, 4);

    // Backpressure: ready 1,0,0,1,0,1,0,0,1,1,0,1 then high.
    pat = 16'b1111_1011_0010_1001;
    bus.start     = 1'b1;
    bus.rd_base   = 8'd2;
    bus.rd_len    = 9'd5;
    bus.out_ready = pat[0];
    tick();
    bus.start = 1'b0;
    n = 0;
    c = 1;
    have_prev = 1'b0;
    prev_data = '0;
    while (n < 5 && c < 60) begin
      bus.out_ready = (c < 16) ? pat[c] : 1'b1;
      if (bus.out_valid) begin
        if (have_prev) check_eq("bp_stable", bus.out_data, prev_data);
        if (bus.out_ready) begin
          check_eq("bp_data", bus.out_data, exp_beat(8'(2 + n)));
          check_eq("bp_last", bus.out_last, (n == 4));
          n++;
          have_prev = 1'b0;
        end else begin
          prev_data = bus.out_data;
          have_prev = 1'b1;
        end
      end
      tick();
      c++;
    end
    check_eq("bp_beats", n, 5);
    check_eq("bp_done", bus.done, 1);
    check_eq("bp_no_extra", bus.out_valid, 0);
    tick();

    // Write and start while busy: write rejected, start ignored.
    bus.start     = 1'b1;
    bus.rd_base   = 8'd0;
    bus.rd_len    = 9'd8;
    bus.out_ready = 1'b0;
    tick();
    bus.start   = 1'b1;
    bus.rd_base = 8'd100;
    bus.rd_len  = 9'd2;
    bus.wr_en   = 1'b1;
    bus.wr_bank = 4'd3;
    bus.wr_addr = 8'd2;
    bus.wr_data = 16'hDEAD;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check_eq("busy_wr_err", bus.wr_err, 1);
    tick();
    check_eq("busy_wr_err_pulse", bus.wr_err, 0);
    drain("busy_drain", 8'd0, 8);
    tick();

    // Out-of-range bank index.
    write_word(12, 3, 16'h1234);
    check_eq("bank12_wr_err", bus.wr_err, 1);
    tick();
    check_eq("bank12_err_pulse", bus.wr_err, 0);
    stream_full("reread", 8'd0, 8);

    // Write accepted in the same cycle as start is visible to the stream.
    bus.start     = 1'b1;
    bus.rd_base   = 8'd8;
    bus.rd_len    = 9'd1;
    bus.out_ready = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_bank   = 4'd0;
    bus.wr_addr   = 8'd8;
    bus.wr_data   = 16'h7777;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check_eq("samecyc_wr_err", bus.wr_err, 0);
    tick();
    exp_v = exp_beat(8'd8);
    exp_v[15:0] = 16'h7777;
    check_eq("samecyc_valid", bus.out_valid, 1);
    check_eq("samecyc_data", bus.out_data, exp_v);
    check_eq("samecyc_last", bus.out_last, 1);
    tick();
    check_eq("samecyc_done", bus.done, 1);
    tick();

    // Zero-length start.
    bus.start  = 1'b1;
    bus.rd_len = 9'd0;
    tick();
    bus.start = 1'b0;
    check_eq("len0_done", bus.done, 1);
    check_eq("len0_valid", bus.out_valid, 0);
    check_eq("len0_busy", bus.busy, 0);
    tick();
    check_eq("len0_done_pulse", bus.done, 0);
    check_eq("len0_valid2", bus.out_valid, 0);

    // Reset at beat 3 of an 8-beat stream.
    bus.start     = 1'b1;
    bus.rd_base   = 8'd0;
    bus.rd_len    = 9'd8;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_eq("mid_beat3", bus.out_data, exp_beat(8'd3));
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_data", bus.out_data, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_last", bus.out_last, 0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_done", bus.done, 0);
    check_eq("post_rst_busy", bus.busy, 0);
    tick();
    check_eq("post_rst_done2", bus.done, 0);
    check_eq("post_rst_valid", bus.out_valid, 0);
    stream_full("post_rst", 8'd0, 8);

`ifdef BROADCAST_WR_EN
    bus.wr_en   = 1'b1;
    bus.wr_bank = '1;
    bus.wr_addr = 8'd5;
    bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    check_eq("bcast_no_err", bus.wr_err, 0);
    bus.start   = 1'b1;
    bus.rd_base = 8'd5;
    bus.rd_len  = 9'd1;
    tick();
    bus.start = 1'b0;
    tick();
    check_eq("bcast_data", bus.out_data, {10{16'hBEEF}});
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sram_bank_array.md
# sram_bank_array

Parametrised multi-bank input memory feeding the datapath. NUM_BANKS single-port synchronous SRAM banks share one read address. A host-side load port fills any bank word by word. A start-triggered read sequencer streams a contiguous, wrapping address range out of all banks in parallel over a valid/ready interface to the downstream multiply/accumulate stage.

## Interface
- NUM_BANKS, 10, number of parallel banks (1..16)
- DATA_W, 16, word width per bank
- DEPTH, 256, words per bank, power of two ≥ 2; ADDR_W = log2(DEPTH), BANK_W = max(1, ceil(log2(NUM_BANKS)))
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  load-port write strobe
- wr_bank  in  BANK_W  target bank
- wr_addr  in  ADDR_W  target word
- wr_data  in  DATA_W  write data
- wr_err  out  1  one-cycle pulse: write rejected
- start  in  1  begin read stream (pulse)
- rd_base  in  ADDR_W  first read address, sampled with start
- rd_len  in  ADDR_W+1  number of beats, 0..DEPTH, sampled with start
- busy  out  1  sequencer not IDLE
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_BANKS*DATA_W  bank k in bits [k*DATA_W +: DATA_W]
- out_last  out  1  final beat of stream, qualified by out_valid
- done  out  1  one-cycle pulse after final handshake

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start with rd_len > 0.
  - start with rd_len = 0: stays IDLE and pulses done the next cycle; no beats.
  - RUN→DRAIN when the last read has been issued.
  - DRAIN→IDLE on the out_last handshake; done pulses the following cycle.
- start while busy is ignored. No error flag for this case.
- Writes are accepted only in IDLE and take effect at the clock edge.
  - wr_en while busy: no write, wr_err pulses next cycle.
  - wr_bank ≥ NUM_BANKS: no write, wr_err pulses next cycle.
  - A write in the same cycle as an accepted start is performed.
- Read address i = (rd_base + i) mod DEPTH, so the range wraps past DEPTH-1 to 0.
- Banks have a one-cycle read latency. Returned words land in a 2-entry output FIFO.
  - A read is issued only if FIFO entries plus reads in flight, minus any pop this cycle, is < 2.
  - Stalls therefore never drop or duplicate data, and throughput is one beat per cycle while out_ready is high.
- out_data and out_last are held stable while out_valid && !out_ready.
- Reset values: FSM IDLE, FIFO empty, counters 0, all outputs 0. Bank contents are not cleared by reset.
- Reset asserted mid-stream aborts immediately. After release the block is IDLE; done is not pulsed for the aborted stream.

## Timing
- Accepted start in cycle T: first read issued in T+1, out_valid first high in T+2.
- With out_ready held high, beat i is presented in cycle T+2+i; out_last in cycle T+1+rd_len.
- done is high in the cycle after the out_last handshake; busy drops in that same cycle.
- wr_err appears the cycle after the offending wr_en.
- A write to address A at edge E is readable by a read issued at or after E (no read-during-write to the same bank can occur, since writes are blocked while busy).

## Configuration
- BROADCAST_WR_EN defined:
  - wr_bank all-ones writes wr_data to wr_addr in every bank at once.
  - That encoding is exempt from the out-of-range wr_err.
  - Needs BANK_W wide enough that all-ones ≥ NUM_BANKS; when NUM_BANKS is a power of two, BANK_W grows by 1.
- Undefined: all-ones is an ordinary bank index, rejected with wr_err if ≥ NUM_BANKS.

## Structure
- Package sram_array_pkg:
  - FSM state enum (IDLE/RUN/DRAIN).
  - Function computing BANK_W.
  - FIFO_DEPTH = 2 constant.
- Sub-module sram_bank: one DATA_W × DEPTH single-port synchronous RAM, ports clk, write, address, wdata, rdata, one-cycle read latency. Instantiated NUM_BANKS times in a generate loop.
- Sequencer, issue counter, beat counter and output FIFO live in the top of this block.

## Test plan
- Load banks 0..9 with word (bank<<8)|addr for addr 0..7; start base 0, len 8, out_ready=1 → 8 beats in cycles T+2..T+9, bank k lane = k<<8|i, out_last on beat 7, done at T+10.
- Wrap: DEPTH=256, base 254, len 4 → addresses 254, 255, 0, 1 in that order.
- Backpressure: len 5, out_ready toggled 1,0,0,1,0,1… → exactly 5 beats, in order, data stable during stalls, no duplicates.
- Errors: wr_en during RUN → memory unchanged, wr_err pulse; wr_bank=12 with NUM_BANKS=10 (no macro) → wr_err, no write.
- start with len 0 → no out_valid, done one cycle later; start while busy → ignored, stream length unchanged.
- Reset asserted at beat 3 of len 8 → outputs 0 immediately, IDLE after release, no done; new start returns the previously loaded data. With BROADCAST_WR_EN, a broadcast write of 0xBEEF to addr 5 is read back from all banks.
